// File: rtl/adc_scan_sequencer.sv
// Round-robin scan controller for the MAX 10 ADC Avalon-ST command/response ports.
// Averages 2^AVERAGE_LOG2 samples per enabled channel and flags mismatched, stray or lost responses.
module adc_scan_sequencer #(
    parameter int CHANNELS       = 17,
    parameter int AVERAGE_LOG2   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clock_clk,
    input  logic                reset_sink_reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] channel_mask,
    input  logic                error_clear,
    output logic                command_valid,
    output logic [4:0]          command_channel,
    output logic                command_startofpacket,
    output logic                command_endofpacket,
    input  logic                command_ready,
    input  logic                response_valid,
    input  logic [4:0]          response_channel,
    input  logic [11:0]         response_data,
    input  logic                response_startofpacket,
    input  logic                response_endofpacket,
    output logic                result_valid,
    output logic [4:0]          result_channel,
    output logic [11:0]         result_data,
    output logic                scan_done,
    output logic                busy,
    output logic [1:0]          error
);

    localparam int CH_W = 5;
    localparam int SW   = 12 + AVERAGE_LOG2;
    localparam int CW   = AVERAGE_LOG2 + 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   r_cur_ch;
    logic              r_last;
    logic [SW-1:0]     r_sum;
    logic [CW-1:0]     r_count;
    logic [TW-1:0]     r_timer;
    logic [1:0]        r_error;
    logic              r_result_valid;
    logic [CH_W-1:0]   r_result_channel;
    logic [11:0]       r_result_data;
    logic              r_scan_done;

    logic              w_mask_any;
    logic [CH_W-1:0]   w_hi_ch;
    logic [CH_W-1:0]   w_lo_ch;
    logic              w_hi_found;
    logic [CH_W-1:0]   w_sel_ch;
    logic              w_sel_last;
    logic [CH_W-1:0]   w_ptr_next;
    logic [SW-1:0]     w_sum_next;
    logic [CW-1:0]     w_count_inc;
    logic              w_match;
    logic              w_final;
    logic              w_timeout;
    logic              w_stray;
    logic              w_command_valid;
    logic              w_busy;
    logic              w_unused_sop_eop;

    assign w_unused_sop_eop = response_startofpacket ^ response_endofpacket;

    assign w_mask_any  = |channel_mask;
    assign w_ptr_next  = (int'(r_cur_ch) == CHANNELS - 1) ? '0 : r_cur_ch + 1'b1;
    assign w_sum_next  = r_sum + SW'(response_data);
    assign w_count_inc = r_count + 1'b1;
    assign w_match     = response_valid && (response_channel == r_cur_ch);
    assign w_final     = (w_count_inc == CW'(1 << AVERAGE_LOG2));
    // A response arriving in the same cycle as the timeout takes precedence.
    assign w_timeout   = (r_state == S_WAIT) && !response_valid && (r_timer == TW'(TIMEOUT_CYCLES));
    assign w_stray     = response_valid && !((r_state == S_WAIT) && w_match);

    // Circular search: lowest set bit at or above r_ptr, else lowest set bit overall.
    always_comb begin
        w_hi_ch    = '0;
        w_lo_ch    = '0;
        w_hi_found = 1'b0;
        w_sel_last = 1'b1;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (channel_mask[j]) begin
                w_lo_ch = CH_W'(j);
                if (j >= int'(r_ptr)) begin
                    w_hi_ch    = CH_W'(j);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_sel_ch = w_hi_found ? w_hi_ch : w_lo_ch;
        for (int j = 0; j < CHANNELS; j++) begin
            if (channel_mask[j] && (j > int'(w_sel_ch))) begin
                w_sel_last = 1'b0;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next_state    = r_state;
        w_command_valid = 1'b0;
        w_busy          = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (enable && w_mask_any) w_next_state = S_SELECT;
            end
            S_SELECT: begin
                w_next_state = w_mask_any ? S_ISSUE : S_IDLE;
            end
            S_ISSUE: begin
                w_command_valid = 1'b1;
                if (command_ready) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (response_valid) begin
                    w_next_state = (w_match && w_final) ? S_EMIT : S_ISSUE;
                end else if (w_timeout) begin
                    w_next_state = enable ? S_SELECT : S_IDLE;
                end
            end
            S_EMIT: begin
                w_next_state = enable ? S_SELECT : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            r_ptr            <= '0;
            r_cur_ch         <= '0;
            r_last           <= 1'b0;
            r_sum            <= '0;
            r_count          <= '0;
            r_timer          <= '0;
            r_result_valid   <= 1'b0;
            r_result_channel <= '0;
            r_result_data    <= '0;
            r_scan_done      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_scan_done    <= 1'b0;
            case (r_state)
                S_SELECT: begin
                    if (w_mask_any) begin
                        r_cur_ch <= w_sel_ch;
                        r_last   <= w_sel_last;
                        r_sum    <= '0;
                        r_count  <= '0;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_match) begin
                        r_sum   <= w_sum_next;
                        r_count <= w_count_inc;
                        // Result registers load on entry to EMIT so they read as a strobe there and hold after.
                        if (w_final) begin
                            r_result_valid   <= 1'b1;
                            r_result_channel <= r_cur_ch;
                            r_result_data    <= w_sum_next[SW-1:AVERAGE_LOG2];
                            r_scan_done      <= r_last;
                        end
                    end else if (w_timeout) begin
                        r_ptr <= w_ptr_next;
                    end
                end
                S_EMIT: begin
                    r_ptr <= w_ptr_next;
                end
                default: ;
            endcase
        end
    end

    // Error bits are sticky; a new event beats error_clear in the same cycle.
    always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            r_error <= 2'b00;
        end else begin
            if (w_stray)          r_error[0] <= 1'b1;
            else if (error_clear) r_error[0] <= 1'b0;
            if (w_timeout)        r_error[1] <= 1'b1;
            else if (error_clear) r_error[1] <= 1'b0;
        end
    end

    assign command_valid         = w_command_valid;
    assign command_channel       = r_cur_ch;
    assign command_startofpacket = w_command_valid;
    assign command_endofpacket   = w_command_valid;
    assign result_valid          = r_result_valid;
    assign result_channel        = r_result_channel;
    assign result_data           = r_result_data;
    assign scan_done             = r_scan_done;
    assign busy                  = w_busy;
    assign error                 = r_error;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: scan with averaging, ready stalls, mismatch,
// timeout, enable drop with resume, and reset with a late stray response.
module tb_adc_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [16:0] channel_mask;
    logic        error_clear;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;
    logic        result_valid;
    logic [4:0]  result_channel;
    logic [11:0] result_data;
    logic        scan_done;
    logic        busy;
    logic [1:0]  error;

    int n_vec = 0;
    int n_err = 0;

    adc_scan_sequencer #(
        .CHANNELS       (17),
        .AVERAGE_LOG2   (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock_clk              (clk),
        .reset_sink_reset       (rst),
        .enable                 (enable),
        .channel_mask           (channel_mask),
        .error_clear            (error_clear),
        .command_valid          (command_valid),
        .command_channel        (command_channel),
        .command_startofpacket  (command_startofpacket),
        .command_endofpacket    (command_endofpacket),
        .command_ready          (command_ready),
        .response_valid         (response_valid),
        .response_channel       (response_channel),
        .response_data          (response_data),
        .response_startofpacket (response_startofpacket),
        .response_endofpacket   (response_endofpacket),
        .result_valid           (result_valid),
        .result_channel         (result_channel),
        .result_data            (result_data),
        .scan_done              (scan_done),
        .busy                   (busy),
        .error                  (error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered on a negedge where the command must already be valid; answers it with one response.
    task automatic sample(input logic [4:0] ch, input logic [4:0] rch, input logic [11:0] data, input int hold);
        check("cmd_valid", 32'(command_valid), 1);
        check("cmd_channel", 32'(command_channel), 32'(ch));
        check("cmd_sop_eop", 32'({command_startofpacket, command_endofpacket}), 3);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("cmd_hold_valid", 32'(command_valid), 1);
            check("cmd_hold_channel", 32'(command_channel), 32'(ch));
        end
        command_ready = 1'b1;
        tick();
        command_ready = 1'b0;
        check("single_cmd", 32'(command_valid), 0);
        response_valid   = 1'b1;
        response_channel = rch;
        response_data    = data;
        tick();
        response_valid   = 1'b0;
    endtask

    // Called the cycle after the final response: checks the strobe, then the following cycle.
    task automatic expect_result(input logic [4:0] ch, input logic [11:0] data, input logic sd);
        check("result_valid", 32'(result_valid), 1);
        check("result_channel", 32'(result_channel), 32'(ch));
        check("result_data", 32'(result_data), 32'(data));
        check("scan_done", 32'(scan_done), 32'(sd));
        tick();
        check("result_strobe_len", 32'(result_valid), 0);
        check("scan_done_len", 32'(scan_done), 0);
        check("result_data_held", 32'(result_data), 32'(data));
        check("no_cmd_after_emit", 32'(command_valid), 0);
    endtask

    initial begin
        rst                    = 1'b1;
        enable                 = 1'b0;
        channel_mask           = '0;
        error_clear            = 1'b0;
        command_ready          = 1'b0;
        response_valid         = 1'b0;
        response_channel       = '0;
        response_data          = '0;
        response_startofpacket = 1'b0;
        response_endofpacket   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_cmd_valid", 32'(command_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_result", 32'({result_valid, result_channel, result_data, scan_done}), 0);
        check("rst_error", 32'(error), 0);
        check("rst_cmd_channel", 32'(command_channel), 0);

        // Pass 1: channels 0 and 2, four samples each.
        channel_mask = 17'h00005;
        enable       = 1'b1;
        tick();
        check("select_busy", 32'(busy), 1);
        check("select_no_cmd", 32'(command_valid), 0);
        tick();
        sample(0, 0, 100, 0);
        sample(0, 0, 101, 0);
        sample(0, 0, 102, 0);
        sample(0, 0, 103, 0);
        expect_result(0, 101, 0);
        tick();
        sample(2, 2, 4000, 0);
        sample(2, 2, 4000, 0);
        sample(2, 2, 4000, 0);
        sample(2, 2, 4000, 0);
        expect_result(2, 4000, 1);
        check("pass1_error", 32'(error), 0);
        tick();

        // Pass 2: ready stalled 7 cycles, then a mismatched response on channel 2.
        sample(0, 0, 10, 7);
        sample(0, 0, 20, 0);
        sample(0, 0, 30, 0);
        sample(0, 0, 41, 0);
        expect_result(0, 25, 0);
        tick();
        sample(2, 3, 999, 0);
        check("mismatch_error", 32'(error), 1);
        sample(2, 2, 4000, 0);
        sample(2, 2, 4000, 0);
        sample(2, 2, 4001, 0);
        sample(2, 2, 4003, 0);
        expect_result(2, 4001, 1);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("clear_error0", 32'(error), 0);

        // Pass 3: channel 0 response lost; timeout then channel 2.
        check("to_cmd_channel", 32'(command_channel), 0);
        check("to_cmd_valid", 32'(command_valid), 1);
        command_ready = 1'b1;
        tick();
        command_ready = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check("to_wait_no_cmd", 32'(command_valid), 0);
            check("to_wait_no_result", 32'(result_valid), 0);
            tick();
        end
        check("to_before_error", 32'(error), 0);
        check("to_still_busy", 32'(busy), 1);
        tick();
        check("to_error", 32'(error), 2);
        check("to_no_result", 32'(result_valid), 0);
        check("to_select_no_cmd", 32'(command_valid), 0);
        tick();
        sample(2, 2, 1, 0);
        sample(2, 2, 2, 0);
        sample(2, 2, 3, 0);
        sample(2, 2, 4, 0);
        expect_result(2, 2, 1);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("clear_error1", 32'(error), 0);

        // Pass 4: enable drops during the second channel 0 sample.
        sample(0, 0, 200, 0);
        enable = 1'b0;
        sample(0, 0, 200, 0);
        check("drop_busy", 32'(busy), 1);
        sample(0, 0, 204, 0);
        sample(0, 0, 208, 0);
        expect_result(0, 203, 0);
        check("drop_idle", 32'(busy), 0);
        tick();
        tick();
        check("drop_stay_idle", 32'(busy), 0);
        check("drop_no_cmd", 32'(command_valid), 0);
        enable = 1'b1;
        tick();
        check("resume_select", 32'(command_valid), 0);
        tick();
        check("resume_cmd_valid", 32'(command_valid), 1);
        check("resume_cmd_ch", 32'(command_channel), 2);

        // Reset while waiting, then the late response arrives as a stray.
        command_ready = 1'b1;
        tick();
        command_ready = 1'b0;
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("async_rst_cmd", 32'({command_valid, command_channel, command_startofpacket, command_endofpacket}), 0);
        check("async_rst_result", 32'({result_valid, result_channel, result_data, scan_done}), 0);
        check("async_rst_busy_err", 32'({busy, error}), 0);
        enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        response_valid   = 1'b1;
        response_channel = 5'd2;
        response_data    = 12'd55;
        tick();
        response_valid   = 1'b0;
        check("stray_error", 32'(error), 1);
        check("stray_idle", 32'({busy, command_valid, result_valid}), 0);
        error_clear = 1'b1;
        tick();
        check("stray_cleared", 32'(error), 0);
        response_valid = 1'b1;
        tick();
        response_valid = 1'b0;
        error_clear    = 1'b0;
        check("set_beats_clear", 32'(error), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Autonomous scan controller for the MAX 10 ADC core's Avalon-ST command/response interface. It steps round-robin through a run-time channel mask and issues one single-sample command at a time. It averages 2^AVERAGE_LOG2 responses per channel and presents each averaged result as a one-cycle strobe to downstream logic. It also detects channel mismatches and lost responses, so the ADC core never stalls the scan.

## Interface

- CHANNELS, 17: number of channel slots scanned (0..CHANNELS-1, max 32).
- AVERAGE_LOG2, 2: log2 of samples averaged per channel (0 = no averaging).
- TIMEOUT_CYCLES, 1024: cycles allowed in WAIT before a response is declared lost.

- clock_clk  in  1  system clock; same clock as the ADC core's clock_clk.
- reset_sink_reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; scanning runs while high.
- channel_mask  in  CHANNELS  bit i enables channel i; sampled in SELECT only.
- error_clear  in  1  pulse; clears error.
- command_valid  out  1  Avalon-ST command valid.
- command_channel  out  5  channel being requested.
- command_startofpacket  out  1  equals command_valid.
- command_endofpacket  out  1  equals command_valid.
- command_ready  in  1  ADC accepts command.
- response_valid  in  1  ADC sample strobe.
- response_channel  in  5  channel of sample.
- response_data  in  12  sample value.
- response_startofpacket, response_endofpacket  in  1 each; ignored.
- result_valid  out  1  one-cycle strobe; averaged result valid.
- result_channel  out  5  channel of result; held until next strobe.
- result_data  out  12  averaged value; held until next strobe.
- scan_done  out  1  one-cycle strobe; last enabled channel of a pass emitted.
- busy  out  1  high in any state except IDLE.
- error  out  2  sticky; bit0 = mismatched or stray response, bit1 = timeout.

## Operation

- Reset: state IDLE, ptr=0, cur_ch=0, sum=0, count=0, timer=0. All outputs are 0.
- IDLE: if enable=1 and channel_mask≠0, go to SELECT; otherwise stay.
- SELECT: cur_ch = first set mask bit at index ≥ptr, searching circularly (wraps to 0). Set last = no set bit above cur_ch. Clear sum and count. Go to ISSUE. If the mask is now 0, go to IDLE.
- ISSUE: command_valid=sop=eop=1 and command_channel=cur_ch. These hold until command_ready=1, then go to WAIT with timer cleared. Per Avalon-ST, valid is never withdrawn before ready.
- WAIT: one outstanding command maximum. The timer increments every cycle.
  - response_valid with response_channel=cur_ch: sum += response_data and count++.
  - If count+1 = 2^AVERAGE_LOG2, go to EMIT; otherwise go to ISSUE.
  - response_valid with a wrong channel: set error[0], discard the sample, go to ISSUE (reissue same sample).
  - timer = TIMEOUT_CYCLES with no response: set error[1], abandon the channel with no result, go to NEXT.
  - A response and the timeout in the same cycle: the response wins.
- EMIT: result_valid=1, result_channel=cur_ch, result_data=sum[11+AVERAGE_LOG2:AVERAGE_LOG2] (truncating). scan_done=last. Falls into NEXT behaviour in the same cycle.
- NEXT (EMIT or timeout exit): ptr=cur_ch+1, wrapping to 0 at CHANNELS. Go to SELECT if enable=1, else IDLE.
- response_valid in any state other than WAIT is a stray: set error[0]; data is ignored.
- enable dropping mid-channel: the current channel completes (all samples or timeout), then the block goes to IDLE. Commands in flight are never orphaned.
- On enable re-assertion, scanning resumes at ptr, not at channel 0.
- error bits: a set takes priority over error_clear in the same cycle.
- Widths: sum is 12+AVERAGE_LOG2 bits and cannot overflow. count is AVERAGE_LOG2+1 bits. The timer is clog2(TIMEOUT_CYCLES+1) bits.

## Timing

- enable is sampled high in IDLE at edge k. SELECT occupies cycle k+1. command_valid is first high in cycle k+2.
- Final accepted response in cycle n: result_valid is high in cycle n+1. The next command_valid is high in cycle n+3 (EMIT, SELECT, ISSUE).
- Non-final response in cycle n: the next command_valid is high in cycle n+1.
- Timeout: error[1] is visible the cycle after timer reaches TIMEOUT_CYCLES. No result_valid is produced for that channel.
- busy falls the cycle after the EMIT/NEXT in which enable=0.
- Reset assertion at any point: outputs clear asynchronously. After release the block waits in IDLE; any response from an outstanding command is counted as a stray.

## Test plan

- mask=0x00005 (ch 0 and 2), AVERAGE_LOG2=2. Model returns 100, 101, 102, 103 for ch0 and 4000 ×4 for ch2. Required: results (0,101), then (2,4000) with scan_done high; repeats while enabled.
- Model holds command_ready low for 7 cycles. Required: command_valid and channel stay stable throughout; exactly one command is accepted.
- Model answers the ch2 command with channel 3. Required: error=01, the sample is discarded, a fifth command is issued on ch2, and the result is still correct.
- Model drops the ch0 response, TIMEOUT_CYCLES=16. Required: error=10 after 16 WAIT cycles, no ch0 result, and the scan continues at ch2.
- enable deasserted during the second ch0 sample. Required: ch0 completes and is emitted, then busy=0. On re-enable the first command is on ch2.
- Reset asserted in WAIT, then a late response arrives. Required: all outputs are 0 and error[0] is set by the stray. error_clear in the same cycle as a new mismatch leaves error[0]=1.
